// File: rtl/pwm_compare_stage.sv
`timescale 1ns / 1ps
// pwm_compare_stage
//   Compares an upstream free-running count against a double-buffered duty value
//   to produce a registered PWM output and a once-per-period pulse.
//
//   Optional feature: define PWM_PERIOD_CNT_EN to add the 8-bit completed-period
//   counter and its output port "periods". Without the macro neither the port
//   nor the register exists.
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cnt          in   [n-1:0] upstream count, 0 .. 2^n-1, wraps to 0
//   enable       in   run control; 0 forces pwm low and suppresses period events
//   duty_in      in   [n-1:0] new duty value
//   duty_wr      in   one-cycle write strobe for duty_in
//   pwm          out  PWM output, one cycle behind cnt
//   period_done  out  one-cycle pulse after each enabled wrap cycle
//   duty_pending out  shadow duty written but not yet applied
//   periods      out  [7:0] completed periods, wraps 255 -> 0 (PWM_PERIOD_CNT_EN only)
module pwm_compare_stage #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] cnt,
  input  logic         enable,
  input  logic [n-1:0] duty_in,
  input  logic         duty_wr,
  output logic         pwm,
  output logic         period_done,
  output logic         duty_pending
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [7:0]   periods
`endif
);

  typedef enum logic {StIdle, StRun} run_state_e;

  localparam logic [n-1:0] CntMax = '1;

  run_state_e   state_q;
  logic [n-1:0] shadow_q;
  logic [n-1:0] active_q;
  logic         pending_q;
  logic         cmp_q;    // cnt < active, sampled on the last edge
  logic         wrap_q;   // last sampled cnt was the wrap value
  logic         wrap;

  assign wrap = (cnt == CntMax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      cmp_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      // Run state follows the sampled enable; no masking of a partial period.
      unique case (state_q)
        StIdle:  state_q <= enable ? StRun : StIdle;
        StRun:   state_q <= enable ? StRun : StIdle;
        default: state_q <= StIdle;
      endcase

      // Compare uses the active duty that was in force during the sampled cycle;
      // active never exceeds CntMax, so the wrap cycle always compares low.
      cmp_q  <= (cnt < active_q);
      wrap_q <= wrap;

      // A write always wins over the wrap transfer; it is applied at the next wrap.
      if (duty_wr) begin
        shadow_q  <= duty_in;
        pending_q <= 1'b1;
      end else if (wrap && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
    end
  end

  // Outputs decode only flop outputs, so there is no path from inputs to outputs.
  assign pwm          = (state_q == StRun) && cmp_q;
  assign period_done  = (state_q == StRun) && wrap_q;
  assign duty_pending = pending_q;

`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] periods_q;

  // Steps on the same edge that raises period_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      periods_q <= 8'd0;
    end else if (enable && wrap) begin
      periods_q <= periods_q + 8'd1;
    end
  end

  assign periods = periods_q;
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
`timescale 1ns / 1ps
module tb_pwm_compare_stage;

  localparam int unsigned N = 4;
  localparam int Per = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] cnt = '0;
  logic         enable = 1'b0;
  logic [N-1:0] duty_in = '0;
  logic         duty_wr = 1'b0;
  logic         pwm;
  logic         period_done;
  logic         duty_pending;
`ifdef PWM_PERIOD_CNT_EN
  logic [7:0]   periods;
`endif

  always #2 clk = ~clk;

  pwm_compare_stage #(
    .n(N)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cnt         (cnt),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_wr     (duty_wr),
    .pwm         (pwm),
    .period_done (period_done),
    .duty_pending(duty_pending)
`ifdef PWM_PERIOD_CNT_EN
    ,
    .periods     (periods)
`endif
  );

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Upstream counter and behavioural model state.
  int cyc = 0;
  int m_shadow, m_active, m_periods;
  bit m_pending;
  bit exp_pwm, exp_pd, exp_pending;
  int exp_periods;
  int dut_hi, dut_pd;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = 0;
    m_active = 0;
    m_pending = 1'b0;
    m_periods = 0;
    exp_pwm = 1'b0;
    exp_pd = 1'b0;
    exp_pending = 1'b0;
    exp_periods = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, optionally pulse reset
  // between edges, predict the post-edge outputs, then sample after the rising edge.
  task automatic cycle(input bit en, input bit wr, input int din, input bit rst_pulse);
    bit n_pwm, n_pd;
    int c;
    @(negedge clk);
    c = cyc % Per;
    cnt = c[N-1:0];
    enable = en;
    duty_wr = wr;
    duty_in = din[N-1:0];
    if (rst_pulse) begin
      #0.5 reset_n = 1'b0;
      #0.5;
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_period_done", int'(period_done), 0);
      chk("rst_duty_pending", int'(duty_pending), 0);
`ifdef PWM_PERIOD_CNT_EN
      chk("rst_periods", int'(periods), 0);
`endif
      model_reset();
      reset_n = 1'b1;
    end
    n_pwm = en && (c < m_active);
    n_pd = en && (c == Per - 1);
    if (wr) begin
      m_shadow = din % Per;
      m_pending = 1'b1;
    end else if (c == Per - 1 && m_pending) begin
      m_active = m_shadow;
      m_pending = 1'b0;
    end
    if (n_pd) m_periods = (m_periods + 1) % 256;
    cyc++;
    @(posedge clk);
    #1;
    exp_pwm = n_pwm;
    exp_pd = n_pd;
    exp_pending = m_pending;
    exp_periods = m_periods;
    dut_hi += int'(pwm);
    dut_pd += int'(period_done);
  endtask

  // One aligned period (cnt 0..15); enable is high for cnt < off_from.
  task automatic run_period(input int wr_at, input int val, input int off_from, input int rst_at);
    dut_hi = 0;
    dut_pd = 0;
    for (int k = 0; k < Per; k++) begin
      cycle(k < off_from, k == wr_at, val, k == rst_at);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pwm", int'(pwm), int'(exp_pwm));
      chk("period_done", int'(period_done), int'(exp_pd));
      chk("duty_pending", int'(duty_pending), int'(exp_pending));
`ifdef PWM_PERIOD_CNT_EN
      chk("periods", int'(periods), exp_periods);
`endif
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_period_done", int'(period_done), 0);
    chk("reset_duty_pending", int'(duty_pending), 0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Write 5 at cnt=3; pending until the wrap edge.
    dut_hi = 0;
    dut_pd = 0;
    for (int k = 0; k < Per; k++) begin
      cycle(1'b1, k == 3, 5, 1'b0);
      if (k == 14) chk("pend_before_wrap", int'(duty_pending), 1);
    end
    chk("pend_after_wrap", int'(duty_pending), 0);
    chk("first_period_hi", dut_hi, 0);
    run_period(-1, 0, Per, -1);
    chk("duty5_hi", dut_hi, 5);
    chk("duty5_pd", dut_pd, 1);

    // Duty 0 then duty 15.
    run_period(2, 0, Per, -1);
    chk("pre_duty0_hi", dut_hi, 5);
    run_period(7, 15, Per, -1);
    chk("duty0_hi", dut_hi, 0);
    chk("duty0_pd", dut_pd, 1);
    run_period(-1, 0, Per, -1);
    chk("duty15_hi", dut_hi, 15);

    // Write coinciding with the wrap cycle is deferred one period.
    run_period(15, 9, Per, -1);
    chk("wrap_wr_hi", dut_hi, 15);
    chk("wrap_wr_pending", int'(duty_pending), 1);
    run_period(-1, 0, Per, -1);
    chk("deferred_hi", dut_hi, 15);
    run_period(-1, 0, Per, -1);
    chk("duty9_hi", dut_hi, 9);

    // Enable dropped at cnt=6: no period event.
    run_period(-1, 0, 6, -1);
    chk("en_off_hi", dut_hi, 6);
    chk("en_off_pd", dut_pd, 0);
    run_period(-1, 0, Per, -1);
    chk("en_on_hi", dut_hi, 9);
    chk("en_on_pd", dut_pd, 1);

    // Duty 5 active, 12 pending, then an asynchronous reset pulse at cnt=8.
    run_period(3, 5, Per, -1);
    chk("pre_rst_hi", dut_hi, 9);
    run_period(4, 12, Per, 8);
    chk("rst_period_hi", dut_hi, 5);
    chk("post_rst_pending", int'(duty_pending), 0);
    run_period(-1, 0, Per, -1);
    chk("post_rst_hi", dut_hi, 0);

    // Randomized phase with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
    end

    // 257 full periods from a reset at cnt=0.
    while (cyc % Per != 0) cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b1);
    for (int i = 1; i < 257 * Per; i++) cycle(1'b1, 1'b0, 0, 1'b0);
`ifdef PWM_PERIOD_CNT_EN
    chk("periods_257", int'(periods), 1);
`endif
    chk("long_run_pending", int'(duty_pending), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_compare_stage.md
PWM_COMPARE_STAGE -- requirements
Module: pwm_compare_stage

Interface
REQ-001 Parameter: n, default 4, width of the count input and duty values.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cnt  input  n  free-running count from the upstream synchronous up counter (0 .. 2^n-1, wraps to 0).
REQ-005 enable  input  1  run control; 0 = output forced low, no period events.
REQ-006 duty_in  input  n  new duty value.
REQ-007 duty_wr  input  1  one-cycle write strobe for duty_in.
REQ-008 pwm  output  1  registered PWM output.
REQ-009 period_done  output  1  registered one-cycle pulse per completed period.
REQ-010 duty_pending  output  1  shadow duty written but not yet applied.
REQ-011 periods  output  8  completed-period count; present only with PWM_PERIOD_CNT_EN.

Function
REQ-012 The block SHALL hold a shadow duty register and an active duty register, both n bits.
REQ-013 When duty_wr=1, shadow SHALL load duty_in on that edge and duty_pending SHALL become 1.
REQ-014 The wrap cycle SHALL be any cycle with cnt = 2^n-1.
REQ-015 On a wrap cycle with duty_pending=1 and duty_wr=0, active SHALL load shadow and duty_pending SHALL clear on that edge.
REQ-016 On a wrap cycle with duty_wr=1, shadow SHALL take duty_in, active SHALL NOT change, and duty_pending SHALL be 1 (applied at the next wrap).
REQ-017 Consecutive duty_wr before a wrap: last value wins; only it is applied.
REQ-018 pwm SHALL be registered: pwm(next) = enable AND (cnt < active); one-cycle latency from cnt.
REQ-019 Boundaries: active=0 -> pwm constantly 0; active=2^n-1 -> pwm 1 for all cnt except 2^n-1; no 100% duty.
REQ-020 period_done SHALL be 1 for exactly the one cycle after a wrap cycle with enable=1; else 0.
REQ-021 enable=0 SHALL NOT block duty writes or shadow-to-active transfer at wrap.
REQ-022 The block SHALL have two run states: IDLE (enable=0, pwm low) and RUN; IDLE->RUN and RUN->IDLE on the edge where enable is sampled changed, with no partial-period masking.
REQ-023 Output changes SHALL depend only on sampled inputs; no combinational input-to-output path.

Reset
REQ-024 reset_n=0 SHALL immediately, independent of clk, force pwm=0, period_done=0, duty_pending=0, shadow=0, active=0, periods=0, state=IDLE.
REQ-025 Reset asserted mid-period SHALL discard any pending duty; after release, operation resumes with active=0 until a write is applied at a wrap.
REQ-026 First edge after reset_n rises SHALL behave as normal operation; no extra wait cycles.

Configuration
REQ-027 Macro PWM_PERIOD_CNT_EN SHALL control the period counter.
REQ-028 With PWM_PERIOD_CNT_EN defined: periods SHALL increment by 1 on each edge where period_done is driven 1, wrapping 255 -> 0.
REQ-029 Without PWM_PERIOD_CNT_EN: port periods and its register SHALL NOT exist; all other behaviour identical.

Verification (n=4, upstream counter driving cnt, clock period 4 ns)
REQ-030 Reset then duty_wr with duty_in=5 at cnt=3 -> duty_pending=1 until the edge at cnt=15; then pwm high for 5 cycles (cnt 0..4, seen one cycle late), low for 11; period_done pulses once per 16 cycles.
REQ-031 duty_in=0 applied -> pwm stays 0 for an entire period; duty_in=15 applied -> pwm low exactly 1 of 16 cycles.
REQ-032 duty_wr=1 with duty_in=9 in the cnt=15 cycle -> active unchanged in following period, duty_pending=1, 9 takes effect after the next wrap.
REQ-033 enable dropped mid-period -> pwm 0 from next edge, no period_done; enable restored -> pwm resumes from the current cnt.
REQ-034 reset_n pulsed low between clock edges with duty 5 active and 12 pending -> all outputs 0 immediately; after release pwm stays 0, duty_pending=0.
REQ-035 With PWM_PERIOD_CNT_EN, run 257 periods -> periods reads 1 (wrapped); without the macro, build passes with periods absent.
